// File: rtl/stopwatch_ctrl.sv
// Stopwatch control FSM: sequences counter enable/clear, captures lap records and picks the display source.
// All outputs registered; state and outputs update on the edge that samples the key pulse.
module stopwatch_ctrl #(
    parameter int TIME_W = 24,
    parameter int DEPTH  = 4,
    parameter int AW     = 2
) (
    input  logic              sys_clk,
    input  logic              sys_rst_n,
    input  logic              sta_sto_p,
    input  logic              clr_p,
    input  logic              store_p,
    input  logic              read_p,
    input  logic [TIME_W-1:0] cur_time,
    output logic              cnt_en,
    output logic              cnt_clr,
    output logic [TIME_W-1:0] disp_time,
    output logic              disp_sel,
    output logic [AW:0]       rec_cnt,
    output logic [AW-1:0]     rec_idx,
    output logic [1:0]        led
);

    typedef enum logic [1:0] {IDLE, RUN, PAUSE, RECALL} state_t;

    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

    state_t            state, nxt_state;
    logic [AW:0]       nxt_cnt;
    logic [AW-1:0]     nxt_idx;
    logic              do_clr, do_wr, full, last_idx;
    logic [TIME_W-1:0] rec_mem [DEPTH];

    assign full     = (rec_cnt == FULL);
    assign last_idx = ({1'b0, rec_idx} == rec_cnt - (AW+1)'(1));

    // A legal but ineffective store (memory full) still consumes the cycle's pulse.
    always_comb begin
        nxt_state = state;
        nxt_cnt   = rec_cnt;
        nxt_idx   = rec_idx;
        do_clr    = 1'b0;
        do_wr     = 1'b0;
        case (state)
            IDLE: begin
                if (clr_p)          do_clr    = 1'b1;
                else if (sta_sto_p) nxt_state = RUN;
            end
            RUN: begin
                if (sta_sto_p)      nxt_state = PAUSE;
                else if (store_p)   do_wr     = !full;
            end
            PAUSE: begin
                if (clr_p) begin
                    nxt_state = IDLE;
                    do_clr    = 1'b1;
                    nxt_cnt   = '0;
                end else if (sta_sto_p) begin
                    nxt_state = RUN;
                end else if (store_p) begin
                    do_wr = !full;
                end else if (read_p && rec_cnt != '0) begin
                    nxt_state = RECALL;
                    nxt_idx   = '0;
                end
            end
            RECALL: begin
                if (clr_p) begin
                    nxt_state = IDLE;
                    do_clr    = 1'b1;
                    nxt_cnt   = '0;
                    nxt_idx   = '0;
                end else if (sta_sto_p) begin
                    nxt_state = PAUSE;
                    nxt_idx   = '0;
                end else if (read_p) begin
                    nxt_idx = last_idx ? '0 : rec_idx + AW'(1);
                end
            end
            default: nxt_state = IDLE;
        endcase
        if (do_wr) nxt_cnt = rec_cnt + (AW+1)'(1);
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state     <= IDLE;
            rec_cnt   <= '0;
            rec_idx   <= '0;
            cnt_en    <= 1'b0;
            cnt_clr   <= 1'b0;
            disp_sel  <= 1'b0;
            disp_time <= '0;
            led       <= '0;
        end else begin
            state     <= nxt_state;
            rec_cnt   <= nxt_cnt;
            rec_idx   <= nxt_idx;
            cnt_en    <= (nxt_state == RUN);
            cnt_clr   <= do_clr;
            disp_sel  <= (nxt_state == RECALL);
            disp_time <= (nxt_state == RECALL) ? rec_mem[nxt_idx] : cur_time;
            led       <= {(nxt_cnt == FULL), (nxt_state == RUN)};
        end
    end

    // Record storage is left unreset; rec_cnt gates every read.
    always_ff @(posedge sys_clk) begin
        if (do_wr) rec_mem[rec_cnt[AW-1:0]] <= cur_time;
    end

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Bench for stopwatch_ctrl: directed scenarios then random key pulses against a queue-based model.
module tb_stopwatch_ctrl;
    localparam int TIME_W = 24;
    localparam int DEPTH  = 4;
    localparam int AW     = 2;

    localparam int M_IDLE = 0, M_RUN = 1, M_PAUSE = 2, M_RECALL = 3;

    logic              sys_clk = 1'b0;
    logic              sys_rst_n = 1'b0;
    logic              sta_sto_p = 1'b0, clr_p = 1'b0, store_p = 1'b0, read_p = 1'b0;
    logic [TIME_W-1:0] cur_time = '0;
    logic              cnt_en, cnt_clr, disp_sel;
    logic [TIME_W-1:0] disp_time;
    logic [AW:0]       rec_cnt;
    logic [AW-1:0]     rec_idx;
    logic [1:0]        led;

    stopwatch_ctrl #(.TIME_W(TIME_W), .DEPTH(DEPTH), .AW(AW)) dut (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n),
        .sta_sto_p(sta_sto_p), .clr_p(clr_p), .store_p(store_p), .read_p(read_p),
        .cur_time(cur_time), .cnt_en(cnt_en), .cnt_clr(cnt_clr),
        .disp_time(disp_time), .disp_sel(disp_sel), .rec_cnt(rec_cnt),
        .rec_idx(rec_idx), .led(led)
    );

    always #5 sys_clk = ~sys_clk;

    int n_assert = 0;
    int n_fail   = 0;

    int                m_mode;
    logic [TIME_W-1:0] m_recs[$];
    int                m_idx;
    bit                m_clr;
    logic [TIME_W-1:0] m_last_time;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_mode = M_IDLE;
        m_recs.delete();
        m_idx = 0;
        m_clr = 1'b0;
        m_last_time = '0;
    endtask

    // Keys are considered in priority order; the first one meaningful in the current mode wins.
    task automatic model_step(input bit s, input bit c, input bit st, input bit r, input logic [TIME_W-1:0] t);
        m_clr = 1'b0;
        if (c && m_mode != M_RUN) begin
            m_mode = M_IDLE;
            m_recs.delete();
            m_idx = 0;
            m_clr = 1'b1;
        end else if (s) begin
            if (m_mode == M_RUN) m_mode = M_PAUSE;
            else if (m_mode == M_RECALL) begin m_mode = M_PAUSE; m_idx = 0; end
            else m_mode = M_RUN;
        end else if (st && (m_mode == M_RUN || m_mode == M_PAUSE)) begin
            if (m_recs.size() < DEPTH) m_recs.push_back(t);
        end else if (r && m_mode == M_PAUSE && m_recs.size() > 0) begin
            m_mode = M_RECALL;
            m_idx = 0;
        end else if (r && m_mode == M_RECALL) begin
            m_idx = (m_idx + 1) % m_recs.size();
        end
        m_last_time = t;
    endtask

    task automatic check_all(input string tag);
        logic [TIME_W-1:0] exp_time;
        exp_time = (m_mode == M_RECALL) ? m_recs[m_idx] : m_last_time;
        chk({tag, ".cnt_en"},    32'(cnt_en),    32'(m_mode == M_RUN));
        chk({tag, ".cnt_clr"},   32'(cnt_clr),   32'(m_clr));
        chk({tag, ".disp_sel"},  32'(disp_sel),  32'(m_mode == M_RECALL));
        chk({tag, ".disp_time"}, 32'(disp_time), 32'(exp_time));
        chk({tag, ".rec_cnt"},   32'(rec_cnt),   32'(m_recs.size()));
        chk({tag, ".rec_idx"},   32'(rec_idx),   32'(m_idx));
        chk({tag, ".led"},       32'(led),       {30'd0, m_recs.size() == DEPTH, m_mode == M_RUN});
    endtask

    task automatic step(input string tag, input bit s, input bit c, input bit st, input bit r,
                        input logic [TIME_W-1:0] t);
        @(negedge sys_clk);
        sta_sto_p = s; clr_p = c; store_p = st; read_p = r; cur_time = t;
        @(posedge sys_clk);
        #1;
        sta_sto_p = 1'b0; clr_p = 1'b0; store_p = 1'b0; read_p = 1'b0;
        model_step(s, c, st, r, t);
        check_all(tag);
    endtask

    task automatic check_zero(input string tag);
        chk({tag, ".cnt_en"},    32'(cnt_en),    32'd0);
        chk({tag, ".cnt_clr"},   32'(cnt_clr),   32'd0);
        chk({tag, ".disp_sel"},  32'(disp_sel),  32'd0);
        chk({tag, ".disp_time"}, 32'(disp_time), 32'd0);
        chk({tag, ".rec_cnt"},   32'(rec_cnt),   32'd0);
        chk({tag, ".rec_idx"},   32'(rec_idx),   32'd0);
        chk({tag, ".led"},       32'(led),       32'd0);
    endtask

    initial begin
        model_reset();
        repeat (2) @(negedge sys_clk);
        check_zero("reset");
        sys_rst_n = 1'b1;

        // T1: start/stop toggles the enable
        step("t1_start", 1, 0, 0, 0, 24'h000001);
        chk("t1_led_run", 32'(led), 32'h1);
        step("t1_stop", 1, 0, 0, 0, 24'h000002);
        chk("t1_en_off", 32'(cnt_en), 32'h0);

        // T2: two laps in RUN, recall with wrap
        step("t2_run", 1, 0, 0, 0, 24'h000100);
        step("t2_st1", 0, 0, 1, 0, 24'h000105);
        step("t2_st2", 0, 0, 1, 0, 24'h000210);
        chk("t2_cnt", 32'(rec_cnt), 32'd2);
        step("t2_pause", 1, 0, 0, 0, 24'h000300);
        step("t2_rd0", 0, 0, 0, 1, 24'h000301);
        chk("t2_rd0_time", 32'(disp_time), 32'h000105);
        step("t2_rd1", 0, 0, 0, 1, 24'h000302);
        chk("t2_rd1_time", 32'(disp_time), 32'h000210);
        step("t2_rd2", 0, 0, 0, 1, 24'h000303);
        chk("t2_wrap_time", 32'(disp_time), 32'h000105);

        // T3: fill memory, fifth store dropped
        step("t3_clr", 0, 1, 0, 0, 24'h0);
        step("t3_run", 1, 0, 0, 0, 24'h0);
        step("t3_pause", 1, 0, 0, 0, 24'h0);
        for (int i = 0; i < DEPTH + 1; i++)
            step("t3_store", 0, 0, 1, 0, 24'h001000 + 24'(i));
        chk("t3_full_led", 32'(led[1]), 32'd1);
        for (int i = 0; i < DEPTH + 1; i++) begin
            step("t3_read", 0, 0, 0, 1, 24'h0);
            chk("t3_read_time", 32'(disp_time), 32'h001000 + 32'(i % DEPTH));
        end

        // T4: clear ignored in RUN, honoured in PAUSE
        step("t4_pause", 1, 0, 0, 0, 24'h0);
        step("t4_run", 1, 0, 0, 0, 24'h0);
        step("t4_clr_run", 0, 1, 0, 0, 24'h0);
        chk("t4_no_clr", 32'(cnt_clr), 32'd0);
        step("t4_pause2", 1, 0, 0, 0, 24'h0);
        step("t4_clr", 0, 1, 0, 0, 24'h0);
        chk("t4_clr_pulse", 32'(cnt_clr), 32'd1);
        step("t4_after", 0, 0, 0, 0, 24'h0);

        // T5: clear beats start/stop in PAUSE
        step("t5_run", 1, 0, 0, 0, 24'h0);
        step("t5_store", 0, 0, 1, 0, 24'h000777);
        step("t5_pause", 1, 0, 0, 0, 24'h0);
        step("t5_both", 1, 1, 0, 0, 24'h0);
        chk("t5_en", 32'(cnt_en), 32'd0);

        // T6: reset mid-RECALL
        step("t6_run", 1, 0, 0, 0, 24'h0);
        step("t6_store", 0, 0, 1, 0, 24'h000555);
        step("t6_pause", 1, 0, 0, 0, 24'h0);
        step("t6_recall", 0, 0, 0, 1, 24'h0);
        @(negedge sys_clk);
        #2 sys_rst_n = 1'b0;
        #1 check_zero("t6_rst");
        model_reset();
        @(negedge sys_clk);
        sys_rst_n = 1'b1;
        step("t6_read_ign", 0, 0, 0, 1, 24'h000042);

        for (int i = 0; i < 400; i++)
            step("rnd", $urandom_range(0, 3) == 0, $urandom_range(0, 9) == 0,
                 $urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0, 24'($urandom));

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
